// File: rtl/grf_pkg.sv
// Shared constants for the general register file storage stage.
package grf_pkg;
    localparam int REG_W  = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/grf_word.sv
// One register word: synchronous active-high clear, load on enable.
module grf_word
    import grf_pkg::*;
#(
    parameter int W = REG_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear dominates load.
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/grf_bank.sv
// Register file storage: 31 stored words plus a hardwired zero slot,
// parallel flattened view for the read selectors, and a write-back trace.
module grf_bank
    import grf_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int NREG   = grf_pkg::NREG,
    parameter bit BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [31:0]           pc,
    output logic [NREG*WIDTH-1:0] regs_flat,
    output logic                  tr_valid,
    output logic [31:0]           tr_pc,
    output logic [ADDR_W-1:0]     tr_addr,
    output logic [WIDTH-1:0]      tr_data,
    output logic [31:0]           wr_count
);

    logic [NREG-1:1]            wsel;
    logic [NREG-1:0][WIDTH-1:0] stored;
    logic [NREG-1:0][WIDTH-1:0] view;

    // One-hot write decode gated by we; slot 0 has no storage to select.
    always_comb begin
        wsel = '0;
        for (int k = 1; k < NREG; k++)
            wsel[k] = we && (waddr == ADDR_W'(k));
    end

    assign stored[0] = '0;

    generate
        for (genvar k = 1; k < NREG; k++) begin : g_word
            grf_word #(.W(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .en    (wsel[k]),
                .d     (wdata),
                .q     (stored[k])
            );
        end
    endgenerate

    // Write-first view: the slot being written shows wdata before the edge,
    // except under reset, where the write is dropped anyway.
    always_comb begin
        view = stored;
        if (BYPASS && !reset) begin
            for (int k = 1; k < NREG; k++)
                if (wsel[k]) view[k] = wdata;
        end
    end

    assign regs_flat = view;

    // Trace record and accepted-write counter; writes to r0 are traced too.
    always_ff @(posedge clk) begin
        if (reset) begin
            tr_valid <= 1'b0;
            tr_pc    <= '0;
            tr_addr  <= REG_ZERO;
            tr_data  <= '0;
            wr_count <= '0;
        end else begin
            tr_valid <= we;
            if (we) begin
                tr_pc    <= pc;
                tr_addr  <= waddr;
                tr_data  <= wdata;
                wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_grf_bank.sv
// Self-checking bench for grf_bank: directed scenarios plus a randomized run
// against an array-based model, with write-first and stored-only instances.
module tb_grf_bank;

    logic          clk = 1'b0;
    logic          reset, we;
    logic [4:0]    waddr;
    logic [31:0]   wdata, pc;
    logic [1023:0] rf1, rf0;
    logic          tv1, tv0;
    logic [31:0]   tpc1, tpc0, td1, td0, wc1, wc0;
    logic [4:0]    ta1, ta0;

    int checks = 0;
    int passes = 0;

    // Reference model
    logic [31:0] mem [32];
    logic        m_tv;
    logic [31:0] m_tpc, m_td, m_cnt;
    logic [4:0]  m_ta;

    grf_bank #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .pc(pc),
        .regs_flat(rf1), .tr_valid(tv1), .tr_pc(tpc1), .tr_addr(ta1),
        .tr_data(td1), .wr_count(wc1)
    );

    grf_bank #(.BYPASS(1'b0)) dut0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata), .pc(pc),
        .regs_flat(rf0), .tr_valid(tv0), .tr_pc(tpc0), .tr_addr(ta0),
        .tr_data(td0), .wr_count(wc0)
    );

    always #5 clk = ~clk;

    // What the read selectors should see right now.
    function automatic logic [1023:0] exp_view(input bit byp);
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = (k == 0) ? 32'd0 : mem[k];
        if (byp && we === 1'b1 && reset === 1'b0 && waddr != 5'd0)
            v[waddr*32 +: 32] = wdata;
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        reset = r; we = w; waddr = a; wdata = d; pc = p;
    endtask

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < 32; k++) mem[k] = 32'd0;
            m_tv = 1'b0; m_tpc = '0; m_ta = '0; m_td = '0; m_cnt = '0;
        end else if (we) begin
            if (waddr != 5'd0) mem[waddr] = wdata;
            m_tv = 1'b1; m_tpc = pc; m_ta = waddr; m_td = wdata;
            m_cnt = m_cnt + 32'd1;
        end else begin
            m_tv = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
        tick(); tick();
        checks++; if (rf1 !== 1024'd0) $display("FAIL reset_flat1 got %h exp 0", rf1); else passes++;
        checks++; if (rf0 !== 1024'd0) $display("FAIL reset_flat0 got %h exp 0", rf0); else passes++;
        checks++; if (tv1 !== 1'b0) $display("FAIL reset_tr_valid got %b exp 0", tv1); else passes++;
        checks++; if (wc1 !== 32'd0) $display("FAIL reset_wr_count got %h exp 0", wc1); else passes++;
        checks++; if (tpc1 !== 32'd0 || ta1 !== 5'd0 || td1 !== 32'd0)
            $display("FAIL reset_trace got pc=%h a=%h d=%h exp 0", tpc1, ta1, td1); else passes++;
    endtask

    task automatic test_write();
        drive(1'b0, 1'b1, 5'd8, 32'h12345678, 32'h00003000);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
        #1;
        checks++; if (rf0[287:256] !== 32'h12345678) $display("FAIL write_reg8 got %h exp 12345678", rf0[287:256]); else passes++;
        checks++; if (tv1 !== 1'b1) $display("FAIL write_tr_valid got %b exp 1", tv1); else passes++;
        checks++; if (tpc1 !== 32'h3000 || ta1 !== 5'd8 || td1 !== 32'h12345678)
            $display("FAIL write_trace got pc=%h a=%h d=%h exp 3000/08/12345678", tpc1, ta1, td1); else passes++;
        checks++; if (wc1 !== 32'd1) $display("FAIL write_count got %h exp 1", wc1); else passes++;
        tick();
        checks++; if (tv1 !== 1'b0 || td1 !== 32'h12345678)
            $display("FAIL idle_trace_hold got v=%b d=%h exp 0/12345678", tv1, td1); else passes++;
    endtask

    task automatic test_zero_write();
        logic [31:0] c0;
        c0 = m_cnt;
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h00003004);
        #1;
        checks++; if (rf1[31:0] !== 32'd0) $display("FAIL zero_bypass got %h exp 0", rf1[31:0]); else passes++;
        tick();
        checks++; if (rf1[31:0] !== 32'd0 || rf0[31:0] !== 32'd0)
            $display("FAIL zero_stored got %h/%h exp 0", rf1[31:0], rf0[31:0]); else passes++;
        checks++; if (tv1 !== 1'b1 || ta1 !== 5'd0 || td1 !== 32'hFFFFFFFF)
            $display("FAIL zero_trace got v=%b a=%h d=%h exp 1/00/ffffffff", tv1, ta1, td1); else passes++;
        checks++; if (wc1 !== c0 + 32'd1) $display("FAIL zero_count got %h exp %h", wc1, c0 + 32'd1); else passes++;
    endtask

    task automatic test_bypass();
        logic [31:0] old;
        old = mem[31];
        drive(1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 32'h00003008);
        #1;
        checks++; if (rf1[1023:992] !== 32'hA5A5A5A5) $display("FAIL bypass_on got %h exp a5a5a5a5", rf1[1023:992]); else passes++;
        checks++; if (rf0[1023:992] !== old) $display("FAIL bypass_off_pre got %h exp %h", rf0[1023:992], old); else passes++;
        tick();
        checks++; if (rf0[1023:992] !== 32'hA5A5A5A5) $display("FAIL bypass_off_post got %h exp a5a5a5a5", rf0[1023:992]); else passes++;
        // Under reset the write is dropped, so nothing may be bypassed.
        drive(1'b1, 1'b1, 5'd31, 32'h5A5A5A5A, 32'h0);
        #1;
        checks++; if (rf1[1023:992] !== 32'hA5A5A5A5) $display("FAIL bypass_reset got %h exp a5a5a5a5", rf1[1023:992]); else passes++;
        tick();
        checks++; if (rf1 !== 1024'd0) $display("FAIL bypass_reset_clear got %h exp 0", rf1); else passes++;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, 5'd3, 32'(i), 32'h4000 + 32'(4*i));
            tick();
            checks++; if (tv1 !== 1'b1 || ta1 !== 5'd3 || td1 !== 32'(i) || tpc1 !== 32'h4000 + 32'(4*i))
                $display("FAIL b2b_trace%0d got v=%b a=%h d=%h pc=%h exp 1/03/%h/%h",
                         i, tv1, ta1, td1, tpc1, 32'(i), 32'h4000 + 32'(4*i)); else passes++;
        end
        checks++; if (rf0[127:96] !== 32'd3) $display("FAIL b2b_reg3 got %h exp 3", rf0[127:96]); else passes++;
        checks++; if (wc1 !== 32'd3) $display("FAIL b2b_count got %h exp 3", wc1); else passes++;
        drive(1'b1, 1'b1, 5'd3, 32'd4, 32'h4010);
        tick();
        checks++; if (rf0[127:96] !== 32'd0 || wc1 !== 32'd0)
            $display("FAIL b2b_reset got reg3=%h cnt=%h exp 0/0", rf0[127:96], wc1); else passes++;
    endtask

    task automatic test_wrap();
        force dut.wr_count  = 32'hFFFFFFFF;
        force dut0.wr_count = 32'hFFFFFFFF;
        #1;
        release dut.wr_count;
        release dut0.wr_count;
        m_cnt = 32'hFFFFFFFF;
        drive(1'b0, 1'b1, 5'd9, 32'h0BADF00D, 32'h5000);
        tick();
        checks++; if (wc1 !== 32'd0 || wc0 !== 32'd0)
            $display("FAIL wrap_count got %h/%h exp 0", wc1, wc0); else passes++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 400; i++) begin
            logic r, w;
            r = ($urandom_range(0, 39) == 0);
            w = ($urandom_range(0, 3) != 0);
            if (w) drive(r, 1'b1, 5'($urandom_range(0, 31)), $urandom, $urandom);
            else   drive(r, 1'b0, 5'bx, $urandom, $urandom);
            #1;
            if (rf1 !== exp_view(1'b1) || rf0 !== exp_view(1'b0)) begin
                errs++;
                if (errs < 5) $display("FAIL rand_view cycle %0d got %h exp %h", i, rf1, exp_view(1'b1));
            end
            tick();
            if (tv1 !== m_tv || tpc1 !== m_tpc || ta1 !== m_ta || td1 !== m_td || wc1 !== m_cnt ||
                tv0 !== m_tv || wc0 !== m_cnt || rf0 !== exp_view(1'b0)) begin
                errs++;
                if (errs < 5) $display("FAIL rand_trace cycle %0d got v=%b pc=%h a=%h d=%h c=%h exp %b/%h/%h/%h/%h",
                                       i, tv1, tpc1, ta1, td1, wc1, m_tv, m_tpc, m_ta, m_td, m_cnt);
            end
        end
        checks++; if (errs != 0) $display("FAIL rand_total got %0d errors exp 0", errs); else passes++;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 32'd0;
        m_tv = 1'b0; m_tpc = '0; m_ta = '0; m_td = '0; m_cnt = '0;
        drive(1'b1, 1'b0, 5'd0, 32'd0, 32'd0);
        @(negedge clk);
        test_reset();
        test_write();
        test_zero_write();
        test_bypass();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/grf_bank.md
Name: grf_bank

Overview:
- Storage stage of the general register file for the single-cycle MIPS datapath.
- Holds 32 x 32-bit registers and performs the decoded, enabled write-back on the clock edge.
- Presents every register word in parallel (flattened bus) to the downstream 32:1 read selectors, one per read port.
- Emits a registered write-back trace record for the grading/debug log.

Parameters:
- WIDTH, 32, data width of each register.
- NREG, 32, number of registers; address width is 5.
- BYPASS, 1, when 1 the flattened output shows a same-cycle write (write-first); when 0 it shows stored values only.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is sampled high.
- we  input  1  write enable.
- waddr  input  5  write register number.
- wdata  input  32  write data.
- pc  input  32  PC of the instruction writing back; used for the trace record only.
- regs_flat  output  1024  register k occupies bits [32k+31:32k]; feeds the read selectors.
- tr_valid  output  1  trace record valid, one cycle after an accepted write.
- tr_pc  output  32  PC of the traced write.
- tr_addr  output  5  register number of the traced write.
- tr_data  output  32  data of the traced write.
- wr_count  output  32  number of accepted writes since reset.

Behaviour:
- Reset: all 32 registers = 0; tr_valid = 0; tr_pc, tr_addr, tr_data = 0; wr_count = 0. Reset has priority over we on the same edge, and the write is dropped.
- Accepted write: we=1 and reset=0 at a rising edge. It is accepted even if waddr=0.
- On an accepted write with waddr!=0: reg[waddr] <= wdata on that edge. All other registers hold.
- Register 0 is never stored and always reads 0. This holds in regs_flat regardless of BYPASS or a write to address 0.
- Trace: on each accepted write, tr_valid<=1, tr_pc<=pc, tr_addr<=waddr, tr_data<=wdata, and wr_count<=wr_count+1. This includes writes to address 0, with tr_data showing the attempted wdata.
- When no write is accepted, tr_valid<=0 and the other trace fields hold their last values.
- wr_count wraps modulo 2^32, from 0xFFFFFFFF to 0.
- Output latency with BYPASS=0: regs_flat updates the cycle after the write edge (registered value).
- Output latency with BYPASS=1: while we=1, reset=0 and waddr!=0, the waddr slot of regs_flat combinationally shows wdata. This satisfies write-then-read within one cycle for the following consumer. With reset=1, no bypass occurs and stored values are shown.
- Back-to-back writes to the same address: the last edge wins, and each write produces its own trace record.
- X on waddr while we=0 has no effect.

Decomposition:
- Shared package: constants REG_W=32, NREG=32, ADDR_W=5, and REG_ZERO=5'd0.
- Sub-module grf_word: one 32-bit register with synchronous active-high clear and write enable. Instantiate 31 copies in a generate loop over addresses 1..31; slot 0 is tied to 0.
- The write decoder (5-to-32 one-hot gated by we) stays inline.

Test Plan:
- Reset with we=1, waddr=5, wdata=0xDEADBEEF held high for 2 cycles -> all of regs_flat = 0, tr_valid=0, wr_count=0.
- After reset, write we=1, waddr=8, wdata=0x12345678, pc=0x00003000 -> next cycle regs_flat[287:256]=0x12345678, tr_valid=1, tr_pc=0x3000, tr_addr=8, wr_count=1.
- Write waddr=0, wdata=0xFFFFFFFF -> regs_flat[31:0] stays 0, tr_valid=1, tr_data=0xFFFFFFFF, wr_count increments.
- BYPASS=1, we=1, waddr=31, wdata=0xA5A5A5A5 -> regs_flat[1023:992]=0xA5A5A5A5 in the same cycle before the edge. BYPASS=0 -> old value until after the edge.
- Writes on consecutive cycles to register 3 with values 1, 2, 3 -> final reg3=3, three trace records in order, wr_count=3. Reset asserted mid-sequence -> reg3=0 and wr_count=0 on the next edge.
- Preload wr_count near wrap by forcing 0xFFFFFFFF, then one write -> wr_count=0.
